// File: rtl/hamming_pkg.sv
// Shared constants, slot state and data-extraction helper for the Hamming(15,11) receive path.
package hamming_pkg;

    localparam int CODE_W = 15;
    localparam int DATA_W = 11;
    localparam int SYN_W  = 4;

    // Codeword indices of the parity bits (Hamming positions 1, 2, 4, 8).
    localparam int PARITY_IDX [SYN_W] = '{0, 1, 3, 7};

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [0:DATA_W-1] extract_data(input logic [0:CODE_W-1] c);
        return {c[2], c[4:6], c[8:14]};
    endfunction

endpackage

// File: rtl/hamming_rx_sched_correct.sv
// Combinational Hamming(15,11) single-error corrector: syndrome, bit flip, data extraction.
module hamming15_correct
    import hamming_pkg::*;
(
    input  logic [0:CODE_W-1] code,
    output logic [0:DATA_W-1] data,
    output logic [SYN_W-1:0]  syn
);

    logic [0:CODE_W-1] fixed;

    always_comb begin
        syn = '0;
        // Syndrome bit j covers every Hamming position whose binary index has the parity bit's weight.
        for (int j = 0; j < SYN_W; j++) begin
            for (int i = 0; i < CODE_W; i++) begin
                if (((i + 1) & (PARITY_IDX[j] + 1)) != 0) begin
                    syn[j] = syn[j] ^ code[i];
                end
            end
        end
        fixed = code;
        for (int i = 0; i < CODE_W; i++) begin
            if (syn == SYN_W'(i + 1)) begin
                fixed[i] = ~code[i];
            end
        end
        data = extract_data(fixed);
    end

endmodule

// File: rtl/hamming_rx_sched.sv
// Two-source round-robin front end sharing one Hamming(15,11) corrector, with a registered output slot
// and per-channel saturating corrected-word counters.
module hamming_rx_sched
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [0:CODE_W-1] in0_code,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [0:CODE_W-1] in1_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] out_data,
    output logic              out_src,
    output logic [SYN_W-1:0]  out_syn,
    output logic              out_corr,
    output logic [CNT_W-1:0]  err_cnt0,
    output logic [CNT_W-1:0]  err_cnt1,
    input  logic              cnt_clr
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high at the rising edge;
    // ready never waits on valid, and a presented output word holds stable until it is accepted.

    slot_state_e       state_q, state_d;
    logic              ptr_q;
    logic              can_load;
    logic              grant;
    logic              xfer;
    logic [0:CODE_W-1] sel_code;
    logic [0:DATA_W-1] cor_data;
    logic [SYN_W-1:0]  cor_syn;
    logic              inc0, inc1;

    assign out_valid = (state_q == SLOT_FULL);
    assign can_load  = !out_valid || out_ready;

    always_comb begin
        grant = 1'b0;
        if (in0_valid && in1_valid) begin
            grant = ptr_q;
        end else if (in1_valid) begin
            grant = 1'b1;
        end
    end

    assign in0_ready = can_load && (grant == 1'b0);
    assign in1_ready = can_load && (grant == 1'b1);
    assign xfer      = can_load && (in0_valid || in1_valid);
    assign sel_code  = grant ? in1_code : in0_code;

    hamming15_correct u_correct (
        .code (sel_code),
        .data (cor_data),
        .syn  (cor_syn)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (xfer) state_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !xfer) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SLOT_EMPTY;
            ptr_q    <= 1'b0;
            out_data <= '0;
            out_src  <= 1'b0;
            out_syn  <= '0;
            out_corr <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                ptr_q    <= ~grant;
                out_data <= cor_data;
                out_src  <= grant;
                out_syn  <= cor_syn;
                out_corr <= (cor_syn != '0);
            end
        end
    end

    assign inc0 = xfer && (grant == 1'b0) && (cor_syn != '0);
    assign inc1 = xfer && (grant == 1'b1) && (cor_syn != '0);

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else begin
            if (inc0 && (err_cnt0 != '1)) err_cnt0 <= err_cnt0 + CNT_W'(1);
            if (inc1 && (err_cnt1 != '1)) err_cnt1 <= err_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_rx_sched.sv
// Randomised plus directed bench for hamming_rx_sched: reference model feeds an expected queue,
// an output monitor pops and compares on every presented word.
module tb_hamming_rx_sched;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst;
    logic        in0_valid, in0_ready;
    logic [0:14] in0_code;
    logic        in1_valid, in1_ready;
    logic [0:14] in1_code;
    logic        out_valid, out_ready;
    logic [0:10] out_data;
    logic        out_src;
    logic [3:0]  out_syn;
    logic        out_corr;
    logic [CNT_W-1:0] err_cnt0, err_cnt1;
    logic        cnt_clr;

    int checks = 0;
    int errors = 0;

    // Expected entry: {src, syn[3:0], data[10:0]} with data MSB = first data bit.
    logic [15:0] exp_q[$];

    int m_full = 0;
    int m_ptr  = 0;
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    hamming_rx_sched #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_code  (in0_code),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_code  (in1_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_syn   (out_syn),
        .out_corr  (out_corr),
        .err_cnt0  (err_cnt0),
        .err_cnt1  (err_cnt1),
        .cnt_clr   (cnt_clr)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: the syndrome is the XOR of the 1-based positions of all set bits;
    // a nonzero syndrome names the position to flip; data are the non-power-of-two positions in order.
    function automatic logic [15:0] ref_decode(input logic src, input logic [0:14] c);
        int          s;
        logic [0:14] f;
        logic [10:0] d;
        s = 0;
        for (int i = 0; i < 15; i++) if (c[i]) s = s ^ (i + 1);
        f = c;
        if (s != 0) f[s-1] = ~f[s-1];
        d = '0;
        for (int i = 0; i < 15; i++) begin
            if (((i + 1) & i) != 0) d = {d[9:0], f[i]};
        end
        return {src, 4'(s), d};
    endfunction

    // ---------------- model step (runs just after the falling edge) ----------------
    task automatic model_step();
        int       can_load, g, x;
        logic [15:0] e;
        check("err_cnt0", 32'(err_cnt0), 32'(m_cnt0));
        check("err_cnt1", 32'(err_cnt1), 32'(m_cnt1));
        check("out_valid", 32'(out_valid), 32'(m_full));
        if (rst) begin
            exp_q.delete();
            m_full = 0;
            m_ptr  = 0;
            m_cnt0 = 0;
            m_cnt1 = 0;
            return;
        end
        can_load = (m_full == 0 || out_ready) ? 1 : 0;
        if (in0_valid && in1_valid) g = m_ptr;
        else if (in1_valid)         g = 1;
        else                        g = 0;
        check("in0_ready", 32'(in0_ready), 32'(can_load != 0 && g == 0));
        check("in1_ready", 32'(in1_ready), 32'(can_load != 0 && g == 1));
        x = (can_load != 0 && (in0_valid || in1_valid)) ? 1 : 0;
        if (x != 0) begin
            e = ref_decode(1'(g), (g == 1) ? in1_code : in0_code);
            exp_q.push_back(e);
            if (e[14:11] != 4'd0) begin
                if (g == 0 && m_cnt0 < CNT_MAX) m_cnt0++;
                if (g == 1 && m_cnt1 < CNT_MAX) m_cnt1++;
            end
            m_ptr = 1 - g;
        end
        if (cnt_clr) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
        end
        if (can_load != 0) m_full = x;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic v0, input logic [0:14] c0, input logic v1, input logic [0:14] c1,
                         input logic ordy, input logic clr, input logic r);
        @(posedge clk);
        #1;
        in0_valid = v0;
        in0_code  = c0;
        in1_valid = v1;
        in1_code  = c1;
        out_ready = ordy;
        cnt_clr   = clr;
        rst       = r;
        @(negedge clk);
        #1;
        model_step();
    endtask

    task automatic idle();
        cycle(1'b0, 15'd0, 1'b0, 15'd0, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=out_valid_1 required=no_word at %0t", $time);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0][10:0]));
                check("out_syn",  32'(out_syn),  32'(exp_q[0][14:11]));
                check("out_src",  32'(out_src),  32'(exp_q[0][15]));
                check("out_corr", 32'(out_corr), 32'(exp_q[0][14:11] != 4'd0));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        in0_valid = 1'b0; in0_code = '0;
        in1_valid = 1'b0; in1_code = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;

        cycle(1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1);
        idle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_out_syn",   32'(out_syn),   32'd0);
        check("rst_out_corr",  32'(out_corr),  32'd0);
        check("rst_err_cnt0",  32'(err_cnt0),  32'd0);
        check("rst_err_cnt1",  32'(err_cnt1),  32'd0);

        // Clean word, single-bit error at index 2, single-bit error at index 14.
        cycle(1'b1, 15'b111000000000000, 1'b0, 15'd0, 1'b1, 1'b0, 1'b0);
        idle();
        check("clean_cnt0", 32'(err_cnt0), 32'd0);
        cycle(1'b0, 15'd0, 1'b1, 15'b110000000000000, 1'b1, 1'b0, 1'b0);
        idle();
        check("err_idx2_cnt1", 32'(err_cnt1), 32'd1);
        cycle(1'b0, 15'd0, 1'b1, 15'b000000000000001, 1'b1, 1'b0, 1'b0);
        idle();
        check("err_idx14_cnt1", 32'(err_cnt1), 32'd2);

        // Round robin with both channels continuously valid.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 1'b0, 1'b0);
        idle();

        // Backpressure: hold a word for 3 cycles, then release with requests pending.
        cycle(1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        // Saturation, then clear racing an errored handshake.
        cycle(1'b0, 15'd0, 1'b0, 15'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 15'b100000000000000, 1'b0, 15'd0, 1'b1, 1'b0, 1'b0);
        idle();
        check("sat_cnt0", 32'(err_cnt0), 32'(CNT_MAX));
        cycle(1'b1, 15'b100000000000000, 1'b0, 15'd0, 1'b1, 1'b1, 1'b0);
        idle();
        check("clr_prio_cnt0", 32'(err_cnt0), 32'd0);

        // Reset while a word is held, then a simultaneous request must go to channel 0.
        cycle(1'b1, 15'b010000000000000, 1'b1, 15'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 15'b010000000000000, 1'b1, 15'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_cnt0",  32'(err_cnt0),  32'd0);
        cycle(1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 15'($urandom), 1'($urandom_range(0, 1)), 15'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 149) == 0));

        for (int i = 0; i < 4; i++) idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_rx_sched.md
Name: hamming_rx_sched

Overview:
- Shares one Hamming(15,11) single-error-correcting stage between two codeword sources using round-robin arbitration.
- Accepts 15-bit codewords via valid/ready, corrects them, and emits 11-bit data with source ID, syndrome and a corrected flag through a registered valid/ready output.
- Keeps per-channel saturating counters of corrected words for link-health monitoring.
- Sits between the receive deserialisers and the downstream data consumer.

Parameters:
- CNT_W, 16, width of each per-channel corrected-word counter (saturating)

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in0_valid  in  1  channel 0 codeword valid
- in0_ready  out  1  channel 0 codeword accepted this cycle when high with in0_valid
- in0_code  in  [0:14]  channel 0 codeword; index i = Hamming position i+1; parity at indices 0,1,3,7
- in1_valid / in1_ready / in1_code  same as channel 0, for channel 1
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_data  out  [0:10]  corrected data = {c[2], c[4:6], c[8:14]}
- out_src  out  1  source channel of out_data
- out_syn  out  4  syndrome of the accepted codeword (0 = no error)
- out_corr  out  1  high when out_syn != 0
- err_cnt0  out  CNT_W  corrected words seen on channel 0
- err_cnt1  out  CNT_W  corrected words seen on channel 1
- cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset: out_valid, out_data, out_src, out_syn, out_corr, err_cnt0, err_cnt1 all 0; priority pointer = channel 0. Mid-operation reset drops any held word; out_valid is 0 the cycle after rst.
- Syndrome, with c = selected codeword:
  - s0 = c0^c2^c4^c6^c8^c10^c12^c14
  - s1 = c1^c2^c5^c6^c9^c10^c13^c14
  - s2 = c3^c4^c5^c6^c11^c12^c13^c14
  - s3 = c7^c8^c9^c10^c11^c12^c13^c14
  - syn = {s3,s2,s1,s0}. If syn != 0, invert c[syn-1]; otherwise pass c unchanged.
  - Double errors are miscorrected silently; there is no detection.
- Output slot: one register stage (states EMPTY/FULL via out_valid).
  - can_load = !out_valid | out_ready.
  - Latency from input handshake to out_valid is exactly 1 cycle.
  - Full throughput is 1 word/cycle while out_ready stays high.
- Arbitration:
  - Grant goes to the only valid channel.
  - If both are valid, grant goes to the pointer channel.
  - inK_ready = can_load & grant==K. inK_ready never depends on the other channel's ready.
  - After each accepted transfer, the pointer moves to the channel that was not granted. Otherwise the pointer holds.
- While out_valid & !out_ready:
  - All out_* hold stable.
  - Both in*_ready = 0.
- Counters:
  - errK increments by 1 when channel K's handshake completes with syn != 0.
  - Counters saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- Inputs are sampled only on a completed handshake. in*_code may change freely otherwise.

Decomposition:
- Shared package hamming_pkg:
  - Constants CODE_W=15, DATA_W=11, SYN_W=4.
  - Parity index list {0,1,3,7}.
  - Function extracting data bits from a corrected codeword.
- One combinational sub-module hamming15_correct:
  - Inputs: code[0:14].
  - Outputs: data[0:10], syn[3:0].
  - Instantiated once, after the arbitration mux.
- The top level holds the arbiter, output register and counters.

Test Plan:
- Clean word: in0_code=15'b111000000000000, out_ready=1 → next cycle out_data=11'b10000000000, out_syn=0, out_corr=0, out_src=0, err_cnt0=0.
- Single-bit error: in1_code=15'b110000000000000 (index 2 flipped) → out_data=11'b10000000000, out_syn=3, out_corr=1, out_src=1, err_cnt1=1. Repeat with index 14 of an all-zero word flipped → out_syn=15, out_data=0.
- Round-robin: both channels valid for 6 cycles, out_ready=1 → out_src sequence 0,1,0,1,0,1; each inK_ready high on alternate cycles.
- Backpressure: out_ready=0 for 3 cycles with a word held → out_* stable, in0_ready=in1_ready=0. When out_ready rises, the new word appears the next cycle with no bubble.
- Counter edges, CNT_W=4:
  - 20 errored words on ch0 → err_cnt0=15.
  - cnt_clr asserted together with an errored handshake → err_cnt0=0.
- Reset mid-stream: rst while out_valid=1 → out_valid=0, counters 0, pointer=0. After release, a simultaneous request grants ch0 first.
